zap_multi_rank_synchronizer: RTL and testbench
==============================================

Name: zap_multi_rank_synchronizer

Overview:
Parametrised successor to the dual-rank synchronizer. It brings WIDTH independent asynchronous level signals (interrupt lines, external status pins) into the i_clk domain through a configurable-depth flop chain, followed by a per-channel stability filter (debounce). Per-channel edge-pulse outputs and a filter-pending flag are also provided. It sits at every asynchronous input boundary of the core and of the SoC peripherals.

Parameters:
WIDTH, 1, number of independent channels (bits); must be at least 1.
STAGES, 2, synchronizer flop depth per channel; must be at least 2; elaboration error if less.
FILTER, 0, consecutive stable cycles required before o_out changes; 0 bypasses the filter.
RESET_VAL, '0 (WIDTH bits), per-channel reset value of the chain, o_out and the edge-history register.

Ports:
i_clk  input  1  single clock; all state is updated on its rising edge.
i_reset  input  1  synchronous, active-high reset.
i_in  input  WIDTH  asynchronous level inputs; no timing relationship to i_clk.
o_out  output  WIDTH  synchronised, filtered level.
o_rise  output  WIDTH  one-cycle pulse when o_out[i] goes 0->1.
o_fall  output  WIDTH  one-cycle pulse when o_out[i] goes 1->0.
o_pending  output  WIDTH  high while channel i's filter counter is non-zero, i.e. a change is being qualified.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_reset).
- Sync chain, per bit: s[0] <= i_in; s[k] <= s[k-1] for k = 1..STAGES-1.
  - tail = s[STAGES-1].
  - No logic between chain flops; the chain is never reset-muxed differently per stage.
- FILTER == 0:
  - o_out = tail. No counters are built.
  - o_pending is tied to 0.
  - Latency from a stable i_in change to o_out is STAGES cycles (+1 for metastability resolution).
- FILTER >= 1, per channel: counter cnt of width $clog2(FILTER+1), reset 0.
  - tail == o_out: cnt <= 0.
  - tail != o_out and cnt == FILTER-1: o_out <= tail; cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
  - o_out therefore changes only after tail has differed from o_out for FILTER consecutive cycles. Latency is STAGES+FILTER cycles.
  - A tail excursion shorter than FILTER cycles clears cnt and produces no o_out change and no pulse.
  - cnt never exceeds FILTER-1; no wrap is possible.
- o_pending[i] = (cnt[i] != 0).
- Edges use history register h <= o_out (reset RESET_VAL):
  - o_rise = o_out & ~h.
  - o_fall = ~o_out & h.
  - Each pulse is exactly 1 cycle. Rise and fall can never be simultaneous on the same bit.
- Channels are fully independent; simultaneous events on different bits are each handled per the rules above.
- Reset behaviour, including reset asserted mid-qualification:
  - On the next edge, all chain flops, o_out and h take RESET_VAL, and cnt takes 0.
  - o_rise, o_fall and o_pending read 0 from that cycle on.
  - No pulse is generated on reset entry or exit, because h == o_out.
- During reset, i_in is ignored. After deassertion, the chain refills over STAGES cycles. If i_in differs from RESET_VAL, a normal qualified edge follows.

Optional Feature:
ZAP_SYNC_EDGE_DETECT_EN
- Defined: h flops are instantiated; o_rise and o_fall behave as specified above.
- Undefined: h is not built; o_rise and o_fall are tied to '0. o_out and o_pending behaviour is unchanged.

Test Plan:
1. Reset/bypass (WIDTH=1, STAGES=2, FILTER=0, RESET_VAL=0): hold i_reset for 3 cycles with i_in=1 -> o_out=0 throughout. Deassert -> o_out=1 exactly 2 cycles later; o_rise high for 1 cycle (with macro defined).
2. Filter qualify (WIDTH=4, STAGES=3, FILTER=4): i_in[2] 0->1 and held -> o_pending[2] high for cycles 4-6 after the change; o_out[2]=1 at cycle 7; o_rise[2] pulses at cycle 7; other bits stay static.
3. Glitch reject (same config): i_in[0]=1 for 3 cycles, then 0 -> o_pending[0] rises and clears; o_out[0] stays 0; no o_rise.
4. Simultaneous channels (same config): i_in 4'b0000 -> 4'b1011 in one cycle -> o_out=4'b1011 at cycle 7; o_rise=4'b1011 for one cycle; o_fall=0.
5. Reset mid-qualification (same config): i_in[1] rises; assert i_reset when cnt[1]=2 -> next cycle cnt=0, o_pending=0, o_out=0, no pulse. After release with i_in[1] still 1 -> o_out[1]=1 seven cycles later.
6. Macro off, RESET_VAL=1 (FILTER=2): i_in toggles 1->0->1 with long holds -> o_out follows with latency STAGES+2; o_rise and o_fall remain 0 at all times.

Source files
------------

// File: rtl/zap_multi_rank_synchronizer.sv
// rtl/zap_multi_rank_synchronizer.sv - multi-bit, multi-stage input synchronizer with debounce filter and edge pulses
//
// Brings WIDTH independent asynchronous level inputs into the i_clk domain
// through a STAGES-deep flop chain, then optionally qualifies each channel
// with a stability filter of FILTER consecutive cycles.
//
// Parameters:
//   WIDTH     - number of independent channels (>= 1)
//   STAGES    - synchronizer depth per channel (>= 2)
//   FILTER    - stable cycles required before o_out changes; 0 bypasses the filter
//   RESET_VAL - per-channel reset value of the chain, o_out and edge history
//
// Ports:
//   i_clk     - clock, all state updates on rising edge
//   i_reset   - synchronous, active-high reset
//   i_in      - asynchronous level inputs
//   o_out     - synchronised, filtered level
//   o_rise    - one-cycle pulse on o_out 0->1
//   o_fall    - one-cycle pulse on o_out 1->0
//   o_pending - channel filter counter is non-zero (change being qualified)
//
// Optional feature macro: ZAP_SYNC_EDGE_DETECT_EN
//   defined   - edge history flops built, o_rise/o_fall active
//   undefined - no history flops, o_rise/o_fall tied to zero

module zap_multi_rank_synchronizer #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 2,
    parameter int              FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_pending
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("zap_multi_rank_synchronizer: STAGES must be at least 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("zap_multi_rank_synchronizer: WIDTH must be at least 1");
        end
    endgenerate

    // Plain flop chain: nothing between stages so each stage has a full
    // cycle to resolve metastability.
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] tail;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= i_in;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign tail = sync_q[STAGES-1];

    generate
        if (FILTER == 0) begin : g_bypass
            assign o_out     = tail;
            assign o_pending = '0;
        end else begin : g_filter
            localparam int             CW       = $clog2(FILTER + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

            logic [CW-1:0]    cnt_q [WIDTH];
            logic [WIDTH-1:0] out_q;

            // cnt counts consecutive cycles the tail has disagreed with
            // o_out; it commits on the FILTER-th such cycle and any
            // agreement in between throws the partial count away.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    out_q <= RESET_VAL;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (tail[i] == out_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            out_q[i] <= tail[i];
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            always_comb begin
                o_pending = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    o_pending[i] = (cnt_q[i] != '0);
                end
            end

            assign o_out = out_q;
        end
    endgenerate

`ifdef ZAP_SYNC_EDGE_DETECT_EN
    // History follows o_out and shares its reset value, so reset entry and
    // exit never look like an edge.
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= o_out;
        end
    end

    assign o_rise = o_out & ~hist_q;
    assign o_fall = ~o_out & hist_q;
`else
    assign o_rise = '0;
    assign o_fall = '0;
`endif

endmodule

// File: tb/tb_zap_multi_rank_synchronizer.sv
// tb/tb_zap_multi_rank_synchronizer.sv - scoreboard bench for zap_multi_rank_synchronizer

module tb_zap_multi_rank_synchronizer;

`ifdef ZAP_SYNC_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    // Three instances: filtered, bypass, and single-cycle filter.
    localparam int         ST [3] = '{3, 2, 4};
    localparam int         FI [3] = '{4, 0, 1};
    localparam logic [3:0] RV [3] = '{4'b0000, 4'b0010, 4'b0101};
    localparam logic [3:0] MK [3] = '{4'b1111, 4'b0011, 4'b0111};

    logic       clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_in;

    logic [3:0] a_out, a_rise, a_fall, a_pend;
    logic [1:0] b_out, b_rise, b_fall, b_pend;
    logic [2:0] c_out, c_rise, c_fall, c_pend;

    always #5 clk = ~clk;

    zap_multi_rank_synchronizer #(
        .WIDTH(4), .STAGES(3), .FILTER(4), .RESET_VAL(4'b0000)
    ) u_a (
        .i_clk(clk), .i_reset(i_reset), .i_in(i_in),
        .o_out(a_out), .o_rise(a_rise), .o_fall(a_fall), .o_pending(a_pend)
    );

    zap_multi_rank_synchronizer #(
        .WIDTH(2), .STAGES(2), .FILTER(0), .RESET_VAL(2'b10)
    ) u_b (
        .i_clk(clk), .i_reset(i_reset), .i_in(i_in[1:0]),
        .o_out(b_out), .o_rise(b_rise), .o_fall(b_fall), .o_pending(b_pend)
    );

    zap_multi_rank_synchronizer #(
        .WIDTH(3), .STAGES(4), .FILTER(1), .RESET_VAL(3'b101)
    ) u_c (
        .i_clk(clk), .i_reset(i_reset), .i_in(i_in[2:0]),
        .o_out(c_out), .o_rise(c_rise), .o_fall(c_fall), .o_pending(c_pend)
    );

    typedef struct packed {
        logic [11:0] o;
        logic [11:0] r;
        logic [11:0] f;
        logic [11:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;

    // Reference state: a sample delay line, a history of synchronized
    // tails (index 0 = most recent), the current filtered level and the
    // level it held one cycle earlier.
    logic [3:0] sh    [3][16];
    logic [3:0] thist [3][16];
    logic [3:0] out_m [3];
    logic [3:0] h_m   [3];

    // o_out flips only when every tail in the last FILTER cycles disagreed
    // with it; pending means the latest tail still disagrees.
    task automatic model_step(input int d, input logic rst, input logic [3:0] inp,
                              output logic [3:0] eo, output logic [3:0] er,
                              output logic [3:0] ef, output logic [3:0] ep);
        logic [3:0] tail_prev, out_prev, nout, ntail;
        bit chg;
        tail_prev = thist[d][0];
        out_prev  = out_m[d];
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                sh[d][k]    = RV[d];
                thist[d][k] = RV[d];
            end
            nout   = RV[d];
            ntail  = RV[d];
            h_m[d] = RV[d];
        end else begin
            for (int k = 15; k > 0; k--) sh[d][k] = sh[d][k-1];
            sh[d][0] = inp & MK[d];
            ntail = sh[d][ST[d]-1];
            if (FI[d] == 0) begin
                nout = ntail;
            end else begin
                nout = out_prev;
                for (int b = 0; b < 4; b++) begin
                    chg = 1'b1;
                    for (int j = 0; j < FI[d]; j++) begin
                        if (thist[d][j][b] == out_prev[b]) chg = 1'b0;
                    end
                    if (chg) nout[b] = ~out_prev[b];
                end
            end
            h_m[d] = out_prev;
            for (int k = 15; k > 0; k--) thist[d][k] = thist[d][k-1];
            thist[d][0] = ntail;
        end
        out_m[d] = nout;
        eo = nout & MK[d];
        er = EDGE_EN ? (nout & ~h_m[d] & MK[d]) : 4'b0;
        ef = EDGE_EN ? (~nout & h_m[d] & MK[d]) : 4'b0;
        ep = (FI[d] > 0 && !rst) ? ((tail_prev ^ nout) & MK[d]) : 4'b0;
    endtask

    task automatic step(input logic rst, input logic [3:0] inp);
        exp_t e;
        logic [3:0] eo, er, ef, ep;
        #1;
        i_reset = rst;
        i_in    = inp;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            model_step(d, rst, inp, eo, er, ef, ep);
            e.o[d*4 +: 4] = eo;
            e.r[d*4 +: 4] = er;
            e.f[d*4 +: 4] = ef;
            e.p[d*4 +: 4] = ep;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int d, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", nm, d, cyc, act, exp_v);
        end
    endtask

    initial begin
        logic [3:0] v;
        i_reset = 1'b1;
        i_in    = 4'hF;
        repeat (3) step(1'b1, 4'hF);
        repeat (10) step(1'b0, 4'hF);
        repeat (12) step(1'b0, 4'h0);
        repeat (12) step(1'b0, 4'b0100);
        repeat (12) step(1'b0, 4'b0000);
        repeat (12) step(1'b0, 4'b1011);
        repeat (12) step(1'b0, 4'b0000);
        repeat (3)  step(1'b0, 4'b0001);
        repeat (12) step(1'b0, 4'b0000);
        repeat (5)  step(1'b0, 4'b0010);
        step(1'b1, 4'b0010);
        repeat (12) step(1'b0, 4'b0010);
        v = 4'b0010;
        for (int n = 0; n < 2500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            end
            step($urandom_range(0, 199) == 0, v);
        end
        repeat (10) step(1'b0, v);
        done = 1'b1;
    end

    initial begin
        exp_t e;
        logic [11:0] ao, ar, af, ap;
        while (!(done && exp_q.size() == 0)) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ao = {1'b0, c_out,  2'b0, b_out,  a_out};
                ar = {1'b0, c_rise, 2'b0, b_rise, a_rise};
                af = {1'b0, c_fall, 2'b0, b_fall, a_fall};
                ap = {1'b0, c_pend, 2'b0, b_pend, a_pend};
                for (int d = 0; d < 3; d++) begin
                    chk("out",  d, ao[d*4 +: 4] & MK[d], e.o[d*4 +: 4]);
                    chk("rise", d, ar[d*4 +: 4] & MK[d], e.r[d*4 +: 4]);
                    chk("fall", d, af[d*4 +: 4] & MK[d], e.f[d*4 +: 4]);
                    chk("pend", d, ap[d*4 +: 4] & MK[d], e.p[d*4 +: 4]);
                end
                cyc++;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
